// File: rtl/alu_mdu_seq_pkg.sv
// alu_mdu_pkg: op encodings, aluc fields and FSM states shared by alu_mdu_seq
// ALU_MDU_DIV_EN defined builds the divider; undefined makes div/divu illegal ops
package alu_mdu_pkg;
  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MFHI  = 5'b10100;
  localparam logic [4:0] OP_MFLO  = 5'b10101;
  localparam logic [1:0] ALU_ARITH = 2'b00;
  localparam logic [1:0] ALU_LOGIC = 2'b01;
  localparam logic [1:0] ALU_XLUI  = 2'b10;
`ifdef ALU_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
endpackage

// File: rtl/alu_mdu_seq_if.sv
// alu_mdu_seq_if: start/busy/done handshake, operands and result registers
interface alu_mdu_seq_if #(parameter int WIDTH = 32);
  logic start;
  logic [4:0] op;
  logic [WIDTH-1:0] x, y, r, hi, lo;
  logic z, v, ill, busy, done;
  modport master (output start, op, x, y, input r, z, v, ill, busy, done, hi, lo);
  modport slave (input start, op, x, y, output r, z, v, ill, busy, done, hi, lo);
endinterface

// File: rtl/alu_mdu_seq_mdu_iter.sv
// mdu_iter: unsigned radix-2 shift-add multiply / restoring divide on operand magnitudes
// The accept edge performs the first iteration, so WIDTH iterations finish WIDTH-1 edges later
module mdu_iter
  import alu_mdu_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] m, ma, mb, c_acc, c_q, c_m, n_acc, n_q;
  logic [WIDTH:0] op_a, op_b, s;
  logic div_r, c_div;
  always_comb begin
    ma = is_signed && a[WIDTH-1] ? -a : a;
    mb = is_signed && b[WIDTH-1] ? -b : b;
    c_div = DIV_EN && (start ? is_div : div_r);
    c_acc = start ? '0 : hi;
    c_q = start ? (c_div ? ma : mb) : lo;
    c_m = start ? (c_div ? mb : ma) : m;
    op_a = c_div ? {c_acc, c_q[WIDTH-1]} : {1'b0, c_acc};
    op_b = c_div ? ~{1'b0, c_m} : (c_q[0] ? {1'b0, c_m} : '0);
    s = op_a + op_b + {{WIDTH{1'b0}}, c_div};
    n_acc = c_div ? (s[WIDTH] ? op_a[WIDTH-1:0] : s[WIDTH-1:0]) : s[WIDTH:1];
    n_q = c_div ? {c_q[WIDTH-2:0], ~s[WIDTH]} : {s[0], c_q[WIDTH-1:1]};
  end
  assign done = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      m <= '0;
      div_r <= 1'b0;
    end else if (start || cnt != '0) begin
      cnt <= start ? CW'(1) : done ? '0 : cnt + 1'b1;
      hi <= n_acc;
      lo <= n_q;
      m <= c_m;
      div_r <= c_div;
    end
endmodule

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: sequential ALU with iterative MDU and HI/LO; ALU_MDU_DIV_EN enables div/divu
module alu_mdu_seq
  import alu_mdu_pkg::*;
#(parameter int WIDTH = 32) (
  input logic clk,
  input logic clrn,
  alu_mdu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  state_t st;
  logic [3:0] aluc;
  logic [SHW-1:0] sa;
  logic [WIDTH-1:0] bb, sum, sra, alu_r, res_b, it_hi, it_lo, hi_n, lo_n, x_r;
  logic [2*WIDTH-1:0] prod_n;
  logic alu_v, ill_b, is_signed, is_div, is_mdu, it_start, it_done;
  logic sx_r, sy_r, div_r, dz_r, ovf_r, mneg;
  always_comb begin
    aluc = bus.op[3:0];
    sa = bus.x[SHW-1:0];
    bb = aluc[2] ? ~bus.y : bus.y;
    sum = bus.x + bb + {{(WIDTH-1){1'b0}}, aluc[2]};
    sra = $signed(bus.y) >>> sa;
    alu_r = aluc[1:0] == ALU_ARITH ? sum :
            aluc[1:0] == ALU_LOGIC ? (aluc[2] ? bus.x | bus.y : bus.x & bus.y) :
            aluc[1:0] == ALU_XLUI ? (aluc[2] ? {bus.y[WIDTH/2-1:0], {(WIDTH/2){1'b0}}} : bus.x ^ bus.y) :
            aluc[2] ? (aluc[3] ? sra : bus.y >> sa) : bus.y << sa;
    alu_v = aluc[1:0] == ALU_ARITH && bus.x[WIDTH-1] == bb[WIDTH-1] && sum[WIDTH-1] != bus.x[WIDTH-1];
    res_b = !bus.op[4] ? alu_r : bus.op == OP_MFHI ? bus.hi : bus.op == OP_MFLO ? bus.lo : '0;
    ill_b = bus.op[4] && bus.op != OP_MFHI && bus.op != OP_MFLO;
    is_signed = !bus.op[0];
    is_div = DIV_EN && (bus.op == OP_DIV || bus.op == OP_DIVU);
    is_mdu = is_div || bus.op == OP_MULT || bus.op == OP_MULTU;
    it_start = bus.start && st == S_IDLE && is_mdu;
    mneg = sx_r ^ sy_r;
    prod_n = -{it_hi, it_lo};
    // divide by zero overrides the iterator; MIN/-1 already wraps to MIN with remainder 0
    hi_n = div_r ? (dz_r ? x_r : sx_r ? -it_hi : it_hi) : mneg ? prod_n[2*WIDTH-1:WIDTH] : it_hi;
    lo_n = div_r ? (dz_r ? '1 : mneg ? -it_lo : it_lo) : mneg ? prod_n[WIDTH-1:0] : it_lo;
  end
  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk), .clrn(clrn), .start(it_start), .is_div(is_div), .is_signed(is_signed),
    .a(bus.x), .b(bus.y), .done(it_done), .hi(it_hi), .lo(it_lo)
  );
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      st <= S_IDLE;
      {sx_r, sy_r, div_r, dz_r, ovf_r} <= '0;
      x_r <= '0;
      bus.r <= '0;
      bus.z <= 1'b1;
      bus.v <= 1'b0;
      bus.ill <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else begin
      bus.done <= 1'b0;
      case (st)
        S_IDLE:
          if (bus.start && is_mdu) begin
            st <= S_RUN;
            bus.busy <= 1'b1;
            sx_r <= is_signed && bus.x[WIDTH-1];
            sy_r <= is_signed && bus.y[WIDTH-1];
            div_r <= is_div;
            dz_r <= bus.y == '0;
            ovf_r <= is_signed && bus.x == {1'b1, {(WIDTH-1){1'b0}}} && &bus.y;
            x_r <= bus.x;
          end else if (bus.start) begin
            bus.r <= res_b;
            bus.z <= res_b == '0;
            bus.v <= !bus.op[4] && alu_v;
            bus.ill <= ill_b;
            bus.done <= 1'b1;
          end
        S_RUN: if (it_done) st <= S_FIX;
        default: begin
          st <= S_IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          bus.hi <= hi_n;
          bus.lo <= lo_n;
          bus.r <= lo_n;
          bus.z <= lo_n == '0;
          bus.v <= div_r && (dz_r || ovf_r);
          bus.ill <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb_alu_mdu_seq: table-driven checks of alu_mdu_seq plus multi-cycle corner sequences
module tb_alu_mdu_seq;
  localparam int W = 32;
  typedef struct {
    logic [4:0] op;
    logic [W-1:0] x, y, r;
    logic v, ill;
    logic [W-1:0] hi, lo;
    int lat;
  } vec_t;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t vt[$];
  alu_mdu_seq_if #(.WIDTH(W)) bus();
  alu_mdu_seq #(.WIDTH(W)) dut(.clk(clk), .clrn(clrn), .bus(bus));
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [4:0] op, logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] r,
                              logic v, logic ill, logic [W-1:0] hi, logic [W-1:0] lo, int lat);
    vec_t t;
    t.op = op; t.x = x; t.y = y; t.r = r; t.v = v; t.ill = ill; t.hi = hi; t.lo = lo; t.lat = lat;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
    bus.op = op; bus.x = x; bus.y = y; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, extra;
    vt.push_back(mk(5'b00000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 0, 0, 0, 1));
    vt.push_back(mk(5'b00100, 32'h5, 32'h5, 32'h0, 0, 0, 0, 0, 1));
    vt.push_back(mk(5'b00100, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1, 0, 0, 0, 1));
    vt.push_back(mk(5'b00000, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 0, 0, 0, 1));
    vt.push_back(mk(5'b00001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 0, 1));
    vt.push_back(mk(5'b00101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0, 0, 1));
    vt.push_back(mk(5'b00010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0, 0, 1));
    vt.push_back(mk(5'b00110, 32'hDEADBEEF, 32'h1234, 32'h12340000, 0, 0, 0, 0, 1));
    vt.push_back(mk(5'b00011, 32'h4, 32'hF, 32'hF0, 0, 0, 0, 0, 1));
    vt.push_back(mk(5'b00111, 32'h4, 32'hF0000000, 32'h0F000000, 0, 0, 0, 0, 1));
    vt.push_back(mk(5'b01111, 32'h4, 32'hF0000000, 32'hFF000000, 0, 0, 0, 0, 1));
    vt.push_back(mk(5'b01111, 32'h1F, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 1));
    vt.push_back(mk(5'b10110, 32'h1, 32'h1, 32'h0, 0, 1, 0, 0, 1));
    vt.push_back(mk(5'b10000, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, W + 1));
    vt.push_back(mk(5'b10100, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1));
    vt.push_back(mk(5'b10001, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 0, 0, 32'h1, 32'hFFFFFFFE, W + 1));
    vt.push_back(mk(5'b10101, 32'h0, 32'h0, 32'hFFFFFFFE, 0, 0, 32'h1, 32'hFFFFFFFE, 1));
    vt.push_back(mk(5'b10000, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'hF, 0, 0, 32'h0, 32'hF, W + 1));
    vt.push_back(mk(5'b10001, 32'h10000, 32'h10000, 32'h0, 0, 0, 32'h1, 32'h0, W + 1));
    vt.push_back(mk(5'b10000, 32'h80000000, 32'h80000000, 32'h0, 0, 0, 32'h40000000, 32'h0, W + 1));
`ifdef ALU_MDU_DIV_EN
    vt.push_back(mk(5'b10010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, W + 1));
    vt.push_back(mk(5'b10011, 32'hFFFFFFF9, 32'h2, 32'h7FFFFFFC, 0, 0, 32'h1, 32'h7FFFFFFC, W + 1));
    vt.push_back(mk(5'b10010, 32'h5, 32'h0, 32'hFFFFFFFF, 1, 0, 32'h5, 32'hFFFFFFFF, W + 1));
    vt.push_back(mk(5'b10010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 32'h0, 32'h80000000, W + 1));
    vt.push_back(mk(5'b10010, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 0, 0, 32'h1, 32'hFFFFFFFD, W + 1));
    vt.push_back(mk(5'b10011, 32'h5, 32'h0, 32'hFFFFFFFF, 1, 0, 32'h5, 32'hFFFFFFFF, W + 1));
`else
    vt.push_back(mk(5'b10010, 32'hFFFFFFF9, 32'h2, 32'h0, 0, 1, 32'h40000000, 32'h0, 1));
    vt.push_back(mk(5'b10011, 32'h5, 32'h0, 32'h0, 0, 1, 32'h40000000, 32'h0, 1));
`endif
    bus.start = 1'b0; bus.op = '0; bus.x = '0; bus.y = '0;
    repeat (2) @(negedge clk);
    chk("rst.r", bus.r, 0);
    chk("rst.z", bus.z, 1);
    chk("rst.v", bus.v, 0);
    chk("rst.ill", bus.ill, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.hi", bus.hi, 0);
    chk("rst.lo", bus.lo, 0);
    clrn = 1'b1;
    @(negedge clk);
    foreach (vt[i]) begin
      issue(vt[i].op, vt[i].x, vt[i].y, lat);
      chk($sformatf("v%0d.lat", i), lat, vt[i].lat);
      chk($sformatf("v%0d.r", i), bus.r, vt[i].r);
      chk($sformatf("v%0d.z", i), bus.z, vt[i].r == 0);
      chk($sformatf("v%0d.v", i), bus.v, vt[i].v);
      chk($sformatf("v%0d.ill", i), bus.ill, vt[i].ill);
      chk($sformatf("v%0d.hi", i), bus.hi, vt[i].hi);
      chk($sformatf("v%0d.lo", i), bus.lo, vt[i].lo);
    end
    // start held high for the whole mult with different operands: must be ignored
    bus.op = 5'b10000; bus.x = 32'd7; bus.y = 32'd6; bus.start = 1'b1;
    @(negedge clk);
    bus.op = 5'b00000; bus.x = 32'd1; bus.y = 32'd1;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    chk("hold.lat", lat, W + 1);
    chk("hold.r", bus.r, 32'h2A);
    chk("hold.hi", bus.hi, 0);
    chk("hold.lo", bus.lo, 32'h2A);
    chk("hold.extra_done", extra, 0);
    // back-to-back: mfhi issued in the done cycle of multu
    issue(5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    chk("b2b.mul_lat", lat, W + 1);
    chk("b2b.lo", bus.lo, 32'h1);
    issue(5'b10100, 32'h0, 32'h0, lat);
    chk("b2b.mfhi_lat", lat, 1);
    chk("b2b.mfhi_r", bus.r, 32'hFFFFFFFE);
    // asynchronous reset in the middle of RUN
    bus.op = 5'b10000; bus.x = 32'd3; bus.y = 32'd4; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort.busy_before", bus.busy, 1);
    clrn = 1'b0;
    #1;
    chk("abort.busy", bus.busy, 0);
    chk("abort.hi", bus.hi, 0);
    chk("abort.lo", bus.lo, 0);
    chk("abort.done", bus.done, 0);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    issue(5'b10000, 32'd3, 32'd4, lat);
    chk("after.lat", lat, W + 1);
    chk("after.r", bus.r, 32'hC);
    chk("after.hi", bus.hi, 0);
    chk("after.lo", bus.lo, 32'hC);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
